// File: rtl/aes_128_pipe.sv
// Fully pipelined AES-128 encryption core: one block per cycle, ciphertext 21 edges after sampling.
// Each block travels with its own round key, so the key may change on every cycle.
module aes_128_pipe (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as b^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (i != 0) inv = gf_mul(inv, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int r);
    case (r)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      default: return 8'h36;
    endcase
  endfunction

  // SubBytes, ShiftRows and (except in the last round) MixColumns; byte i sits at row i%4, column i/4.
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        sr[4*c+j] = sb[4*((c+j)%4)+j];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last)
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // s_q[r]/k_q[r]: state after AddRoundKey r and its round key; a_q/ka_q: the mid-round stage.
  logic [127:0] s_q  [0:10];
  logic [127:0] k_q  [0:9];
  logic [127:0] a_q  [1:10];
  logic [127:0] ka_q [1:10];
  logic [127:0] a_d  [1:10];
  logic [127:0] ka_d [1:10];

  always_comb begin
    for (int r = 1; r <= 10; r++) begin
      a_d[r]  = round_fn(s_q[r-1], r == 10);
      ka_d[r] = key_next(k_q[r-1], rcon(r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r <= 10; r++) s_q[r] <= '0;
      for (int r = 0; r <= 9; r++)  k_q[r] <= '0;
      for (int r = 1; r <= 10; r++) begin
        a_q[r]  <= '0;
        ka_q[r] <= '0;
      end
      out <= '0;
    end else begin
      s_q[0] <= state ^ key;
      k_q[0] <= key;
      for (int r = 1; r <= 10; r++) begin
        a_q[r]  <= a_d[r];
        ka_q[r] <= ka_d[r];
        s_q[r]  <= a_q[r] ^ ka_q[r];
      end
      for (int r = 1; r <= 9; r++) k_q[r] <= ka_q[r];
      // Final register puts the ciphertext on out 21 edges after the inputs were sampled.
      out <= s_q[10];
    end
  end

endmodule

// File: tb/tb_aes_128_pipe.sv
// Bench for aes_128_pipe: known-answer vectors, LFSR and $urandom streams checked against a
// byte-level AES-128 reference, with asynchronous reset mid-stream.
module tb_aes_128_pipe;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] state = '0;
  logic [127:0] key = '0;
  logic [127:0] out;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [127:0] exp_q[$];
  int           due_q[$];
  logic         ne_armed = 1'b0;
  int           ne_due = 0;
  logic [127:0] ne_val = '0;
  logic [7:0]   sbox_t [256];

  aes_128_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .state (state),
    .key   (key),
    .out   (out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    repeat (255) begin
      p = p ^ (p << 1) ^ ((p & 8'h80) != 0 ? 8'h1b : 8'h00);
      q ^= q << 1;
      q ^= q << 2;
      q ^= q << 4;
      if ((q & 8'h80) != 0) q ^= 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      sbox_t[p] = x;
    end
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a [4];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sbox_t[st[((i/4 + i%4) % 4)*4 + i%4]];
      for (int c = 0; c < 4; c++) begin
        for (int j = 0; j < 4; j++) a[j] = tmp[4*c+j];
        for (int j = 0; j < 4; j++) begin
          if (rnd < 10)
            st[4*c+j] = gmul(a[j], 8'h02) ^ gmul(a[(j+1)%4], 8'h03) ^ a[(j+2)%4] ^ a[(j+3)%4];
          else
            st[4*c+j] = a[j];
          st[4*c+j] ^= w[4*rnd+c][31-8*j -: 8];
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] lfsr_step(input logic [127:0] l);
    return {l[126:0], l[127] ^ l[28] ^ l[26] ^ l[1]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [127:0] st, input logic [127:0] k, input logic [127:0] ex);
    state = st;
    key   = k;
    exp_q.push_back(ex);
    due_q.push_back(cyc + 22);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_kat_b();
    ne_armed = 1'b1;
    ne_due   = cyc + 21;
    ne_val   = CT_B;
    drive(PT_B, KEY_B, CT_B);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (out !== 128'h0) begin
      n_fail++;
      $display("FAIL %s out=%h required 0", name, out);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [127:0] ex;
    if (rst_n) begin
      n_checks++;
      if ($isunknown(out)) begin
        n_fail++;
        $display("FAIL xcheck cyc=%0d out=%h required no X", cyc, out);
      end
      if (ne_armed && cyc == ne_due) begin
        n_checks++;
        ne_armed = 1'b0;
        if (out === ne_val) begin
          n_fail++;
          $display("FAIL early_out cyc=%0d out=%h appeared one edge early", cyc, out);
        end
      end
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed cyc=%0d due=%0d expected=%h", cyc, due_q[0], exp_q[0]);
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        ex = exp_q.pop_front();
        n_checks++;
        if (out !== ex) begin
          n_fail++;
          $display("FAIL ciphertext cyc=%0d out=%h required %h", cyc, out, ex);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] ls, lk, rs, rk;
    int           guard;
    build_sbox();
    ls = {4{32'hDEADBEEF}};
    lk = {4{32'hCAFEFEED}};

    #1 rst_n = 1'b0;
    #1 check_zero("reset_out");
    repeat (3) @(posedge clk);
    #1 check_zero("reset_hold");
    #1 rst_n = 1'b1;

    // Known answers streamed back to back, then the zero vector held.
    drive_kat_b();
    drive(PT_C, KEY_C, CT_C);
    drive('0, '0, CT_Z);
    repeat (3) drive('0, '0, CT_Z);

    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        #1 rst_n = 1'b0;
        #1 check_zero("reset_async");
        exp_q.delete();
        due_q.delete();
        ne_armed = 1'b0;
        @(posedge clk);
        #1 check_zero("reset_mid_hold");
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive_kat_b();
      end
      drive(ls, lk, aes_ref(ls, lk));
      ls = lfsr_step(ls);
      lk = lfsr_step(lk);
    end

    // Key-only, state-only and joint changes from $urandom.
    rs = ls;
    rk = lk;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       rs = {$urandom, $urandom, $urandom, $urandom};
        1:       rk = {$urandom, $urandom, $urandom, $urandom};
        default: begin
          rs = {$urandom, $urandom, $urandom, $urandom};
          rk = {$urandom, $urandom, $urandom, $urandom};
        end
      endcase
      drive(rs, rk, aes_ref(rs, rk));
    end

    guard = 0;
    while (due_q.size() > 0 && guard < 40) begin
      @(negedge clk);
      #1 guard++;
    end
    if (due_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required 0", due_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
